// File: rtl/qspi_rd_prefetch_pkg.sv
// Shared constants and FSM encoding for the QSPI read prefetcher.
package qspi_sim_pkg;

  localparam int ADDR_W_DEF   = 24;
  localparam int DATA_W       = 16;
  localparam int PF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } pf_state_t;

endpackage

// File: rtl/qspi_rd_prefetch_if.sv
// Bus bundle between the QSPI front end, the SDRAM read port and the byte serializer.
interface qspi_rd_prefetch_if
  import qspi_sim_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_avalid;
  logic              rd_aready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              busy;

  modport slave (
    input  req_addr, req_valid, abort, rd_aready, rd_data, rd_valid, byte_ready,
    output rd_addr, rd_avalid, rd_ready, byte_data, byte_valid, busy
  );

  modport master (
    output req_addr, req_valid, abort, rd_aready, rd_data, rd_valid, byte_ready,
    input  rd_addr, rd_avalid, rd_ready, byte_data, byte_valid, busy
  );

endinterface

// File: rtl/qspi_rd_prefetch_fifo.sv
// Show-ahead word FIFO holding prefetched SDRAM words; flush clears it in one cycle.
module pf_word_fifo
  import qspi_sim_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH_DEF,
  parameter int WIDTH = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push-while-full succeeds alongside it.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush has priority over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array needs no reset; the occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/qspi_rd_prefetch.sv
// Streams flash bytes to the QSPI serializer by prefetching 16-bit SDRAM words.
module qspi_rd_prefetch
  import qspi_sim_pkg::*;
#(
  parameter int PF_DEPTH = PF_DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  qspi_rd_prefetch_if.slave bus
);

  localparam int OW = $clog2(PF_DEPTH) + 1;
  localparam int SW = OW + 1;
  localparam int PW = ADDR_W - 1;

  pf_state_t         state;
  pf_state_t         state_next;
  logic [ADDR_W-1:0] word_ptr;
  logic              byte_sel;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     outstanding_next;
  logic [OW-1:0]     fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_flush;
  logic              fifo_push;
  logic              fifo_pop;
  logic              start;
  logic              credit_ok;
  logic              avalid;
  logic              rready;
  logic              bvalid;
  logic              issue;
  logic              ret;
  logic              byte_fire;

  // Requests in flight plus words already buffered can never exceed the FIFO depth.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SW'(PF_DEPTH);
  assign start     = (state == ST_IDLE) && bus.req_valid && !bus.abort;
  assign avalid    = (state == ST_FETCH) && credit_ok;
  assign rready    = (state != ST_IDLE);
  assign bvalid    = (state == ST_FETCH) && !fifo_empty;
  assign issue     = avalid && bus.rd_aready;
  assign ret       = bus.rd_valid && rready;
  assign byte_fire = bvalid && bus.byte_ready;

  assign fifo_flush = (state != ST_FETCH) || bus.abort;
  assign fifo_push  = (state == ST_FETCH) && ret;
  assign fifo_pop   = byte_fire && byte_sel;

  assign outstanding_next = outstanding + OW'(issue) - OW'(ret);

  assign bus.rd_addr    = word_ptr;
  assign bus.rd_avalid  = avalid;
  assign bus.rd_ready   = rready;
  assign bus.byte_valid = bvalid;
  assign bus.byte_data  = bvalid ? (byte_sel ? fifo_head[15:8] : fifo_head[7:0]) : 8'h00;
  assign bus.busy       = (state != ST_IDLE);

  pf_word_fifo #(
    .DEPTH (PF_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (bus.rd_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: abort leaves FETCH, via DRAIN only while reads are still owed.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: if (bus.abort) state_next = (outstanding_next != '0) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (outstanding_next == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Word pointer wraps within the 23-bit word space; byte select walks even/odd bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_ptr    <= '0;
      byte_sel    <= 1'b0;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (start) begin
        word_ptr <= {1'b0, bus.req_addr[ADDR_W-1:1]};
        byte_sel <= bus.req_addr[0];
      end else begin
        if (issue)     word_ptr <= {1'b0, word_ptr[PW-1:0] + PW'(1)};
        if (byte_fire) byte_sel <= ~byte_sel;
      end
    end
  end

endmodule

// File: tb/tb_qspi_rd_prefetch.sv
// Directed self-checking bench for qspi_rd_prefetch with a 3-cycle SDRAM responder.
module tb_qspi_rd_prefetch;

  logic        clk;
  logic        rst;
  int          n_cmp;
  int          n_err;
  int          ret_count;
  logic [7:0]  got_q[$];
  logic [23:0] iss_q[$];
  logic        hs_n;
  logic [23:0] hs_addr_n;
  logic        p_v0, p_v1, p_v2;
  logic [23:0] p_a0, p_a1, p_a2;

  qspi_rd_prefetch_if #(.ADDR_W(24)) bus ();

  qspi_rd_prefetch #(
    .PF_DEPTH (4),
    .ADDR_W   (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flash content: byte at address b.
  function automatic logic [7:0] fbyte(input logic [23:0] b);
    return b[7:0] ^ b[15:8] ^ b[23:16] ^ 8'hA5;
  endfunction

  // SDRAM word w holds flash bytes 2w (low) and 2w+1 (high).
  function automatic logic [15:0] word_data(input logic [23:0] w);
    logic [23:0] b;
    b = {w[22:0], 1'b0};
    return {fbyte(b | 24'h1), fbyte(b)};
  endfunction

  // Monitor: records handshakes that will complete on the coming rising edge.
  initial begin
    hs_n      = 1'b0;
    hs_addr_n = '0;
    ret_count = 0;
    forever begin
      @(negedge clk);
      hs_n      = (bus.rd_avalid === 1'b1) && (bus.rd_aready === 1'b1);
      hs_addr_n = bus.rd_addr;
      if (hs_n) iss_q.push_back(bus.rd_addr);
      if ((bus.byte_valid === 1'b1) && (bus.byte_ready === 1'b1)) got_q.push_back(bus.byte_data);
      if ((bus.rd_valid === 1'b1) && (bus.rd_ready === 1'b1)) ret_count++;
    end
  end

  // SDRAM responder: data returns three cycles after the address is accepted.
  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    p_v0 = 1'b0; p_v1 = 1'b0; p_v2 = 1'b0;
    p_a0 = '0;   p_a1 = '0;   p_a2 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        p_v0 = 1'b0; p_v1 = 1'b0; p_v2 = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
      end else begin
        p_v2 = p_v1; p_a2 = p_a1;
        p_v1 = p_v0; p_a1 = p_a0;
        p_v0 = hs_n; p_a0 = hs_addr_n;
        bus.rd_valid = p_v2;
        bus.rd_data  = p_v2 ? word_data(p_a2) : 16'h0000;
      end
    end
  end

  task automatic start_req(input logic [23:0] a);
    @(posedge clk);
    #1;
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      if (got_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic stop_stream(output bit ok);
    @(posedge clk);
    #1;
    bus.abort = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.rd_avalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_avalid: got %0b want 0", bus.rd_avalid); end
    n_cmp++; if (bus.rd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rready: got %0b want 0", bus.rd_ready); end
    n_cmp++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_bvalid: got %0b want 0", bus.byte_valid); end
    n_cmp++; if (bus.rd_addr !== 24'h0) begin n_err++; $display("[TB] FAIL reset_addr: got %0h want 0", bus.rd_addr); end
    n_cmp++; if (bus.byte_data !== 8'h0) begin n_err++; $display("[TB] FAIL reset_bdata: got %0h want 0", bus.byte_data); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL idle_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_stream();
    bit          ok;
    logic [7:0]  exp_b [8] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [23:0] a;
    got_q.delete();
    iss_q.delete();
    bus.rd_aready  = 1'b1;
    bus.byte_ready = 1'b1;
    start_req(24'h000100);
    n_cmp++; if (bus.rd_avalid !== 1'b1) begin n_err++; $display("[TB] FAIL stream_avalid_lat: got %0b want 1", bus.rd_avalid); end
    n_cmp++; if (bus.rd_addr !== 24'h000080) begin n_err++; $display("[TB] FAIL stream_first_addr: got %0h want 80", bus.rd_addr); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("[TB] FAIL stream_busy: got %0b want 1", bus.busy); end
    wait_bytes(8, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL stream_timeout: got %0d bytes want 8", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < iss_q.size()) ? iss_q[i] : 24'hxxxxxx;
      n_cmp++; if (a !== 24'h000080 + 24'(i)) begin n_err++; $display("[TB] FAIL stream_addr%0d: got %0h want %0h", i, a, 24'h000080 + 24'(i)); end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        n_err++; $display("[TB] FAIL stream_byte%0d: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    stop_stream(ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL stream_stop: busy %0b want 0", bus.busy); end
  endtask

  task automatic test_odd_start();
    bit ok;
    got_q.delete();
    iss_q.delete();
    start_req(24'h000101);
    n_cmp++; if (bus.rd_addr !== 24'h000080) begin n_err++; $display("[TB] FAIL odd_addr: got %0h want 80", bus.rd_addr); end
    wait_bytes(2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL odd_timeout: got %0d bytes want 2", got_q.size()); end
    n_cmp++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin n_err++; $display("[TB] FAIL odd_byte0: got %0h want a5", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    n_cmp++; if (got_q.size() < 2 || got_q[1] !== 8'hA6) begin n_err++; $display("[TB] FAIL odd_byte1: got %0h want a6", (got_q.size() > 1) ? got_q[1] : 8'hxx); end
    stop_stream(ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL odd_stop: busy %0b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    got_q.delete();
    iss_q.delete();
    bus.byte_ready = 1'b0;
    start_req(24'h000200);
    repeat (50) @(negedge clk);
    n_cmp++; if (iss_q.size() != 4) begin n_err++; $display("[TB] FAIL bp_issued: got %0d want 4", iss_q.size()); end
    n_cmp++; if (bus.rd_avalid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_avalid: got %0b want 0", bus.rd_avalid); end
    n_cmp++; if (bus.byte_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_bvalid: got %0b want 1", bus.byte_valid); end
    n_cmp++; if (bus.byte_data !== 8'hA7) begin n_err++; $display("[TB] FAIL bp_bdata: got %0h want a7", bus.byte_data); end
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.byte_data !== 8'hA7) begin n_err++; $display("[TB] FAIL bp_hold: got %0h want a7", bus.byte_data); end
    @(posedge clk);
    #1;
    bus.byte_ready = 1'b1;
    wait_bytes(12, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL bp_timeout: got %0d bytes want 12", got_q.size()); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== (8'hA7 ^ 8'(i))) begin
        n_err++; $display("[TB] FAIL bp_byte%0d: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, 8'hA7 ^ 8'(i));
      end
    end
    stop_stream(ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL bp_stop: busy %0b want 0", bus.busy); end
  endtask

  task automatic test_wrap();
    bit         ok;
    logic [7:0] exp_b [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    got_q.delete();
    iss_q.delete();
    start_req(24'hFFFFFE);
    n_cmp++; if (bus.rd_addr !== 24'h7FFFFF) begin n_err++; $display("[TB] FAIL wrap_first: got %0h want 7fffff", bus.rd_addr); end
    wait_bytes(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL wrap_timeout: got %0d bytes want 4", got_q.size()); end
    n_cmp++; if (iss_q.size() < 2 || iss_q[1] !== 24'h000000) begin n_err++; $display("[TB] FAIL wrap_second: got %0h want 0", (iss_q.size() > 1) ? iss_q[1] : 24'hxxxxxx); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        n_err++; $display("[TB] FAIL wrap_byte%0d: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    stop_stream(ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL wrap_stop: busy %0b want 0", bus.busy); end
  endtask

  task automatic test_abort();
    bit ok;
    int base;
    logic [7:0] exp_b [4] = '{8'hA6, 8'hA7, 8'hA4, 8'hA5};
    got_q.delete();
    iss_q.delete();
    start_req(24'h000280);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.abort     = 1'b1;
    bus.rd_aready = 1'b0;
    base = ret_count;
    n_cmp++; if (iss_q.size() != 2) begin n_err++; $display("[TB] FAIL abort_issued: got %0d want 2", iss_q.size()); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("[TB] FAIL abort_bvalid: got %0b want 0", bus.byte_valid); end
    n_cmp++; if (bus.rd_avalid !== 1'b0) begin n_err++; $display("[TB] FAIL abort_avalid: got %0b want 0", bus.rd_avalid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("[TB] FAIL abort_drain_busy: got %0b want 1", bus.busy); end
    n_cmp++; if (bus.rd_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort_drain_rready: got %0b want 1", bus.rd_ready); end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1'b1;
    end
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL abort_idle: busy %0b want 0", bus.busy); end
    n_cmp++; if (ret_count - base != 2) begin n_err++; $display("[TB] FAIL abort_drained: got %0d want 2", ret_count - base); end
    @(posedge clk);
    #1;
    bus.rd_aready = 1'b1;
    bus.req_addr  = 24'h000600;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_req_same: busy %0b want 0", bus.busy); end
    got_q.delete();
    iss_q.delete();
    start_req(24'h000300);
    n_cmp++; if (bus.rd_addr !== 24'h000180) begin n_err++; $display("[TB] FAIL refetch_addr: got %0h want 180", bus.rd_addr); end
    wait_bytes(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL refetch_timeout: got %0d bytes want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        n_err++; $display("[TB] FAIL refetch_byte%0d: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    stop_stream(ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL refetch_stop: busy %0b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] exp_b [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    got_q.delete();
    iss_q.delete();
    start_req(24'h000400);
    wait_bytes(2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rstmid_timeout: got %0d bytes want 2", got_q.size()); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.rd_avalid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_avalid: got %0b want 0", bus.rd_avalid); end
    n_cmp++; if (bus.rd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_rready: got %0b want 0", bus.rd_ready); end
    n_cmp++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_bvalid: got %0b want 0", bus.byte_valid); end
    n_cmp++; if (bus.rd_addr !== 24'h0) begin n_err++; $display("[TB] FAIL rstmid_addr: got %0h want 0", bus.rd_addr); end
    n_cmp++; if (bus.byte_data !== 8'h0) begin n_err++; $display("[TB] FAIL rstmid_bdata: got %0h want 0", bus.byte_data); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rd_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rstrel_rready: got %0b want 0", bus.rd_ready); end
    n_cmp++; if (bus.byte_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstrel_bvalid: got %0b want 0", bus.byte_valid); end
    got_q.delete();
    iss_q.delete();
    start_req(24'h000500);
    wait_bytes(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rstnew_timeout: got %0d bytes want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i]) begin
        n_err++; $display("[TB] FAIL rstnew_byte%0d: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    stop_stream(ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL rstnew_stop: busy %0b want 0", bus.busy); end
  endtask

  // Test sequence.
  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    bus.req_addr   = '0;
    bus.req_valid  = 1'b0;
    bus.abort      = 1'b0;
    bus.rd_aready  = 1'b1;
    bus.byte_ready = 1'b1;
    $display("[TB] qspi_rd_prefetch directed tests start");
    test_reset();
    test_stream();
    test_odd_start();
    test_backpressure();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
